// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter draining a first-word-fall-through TX FIFO
//
// Sends 8N1 or 8N2 frames (start 0, data LSB first, STOP_BITS stop bits of 1).
// A byte is popped whenever the transmitter is idle, or finishing its last stop
// bit, and the FIFO is non-empty. Consecutive frames are sent with no idle gap.
//
// Ports:
//   CLK_I        clock, rising edge
//   RST_I        synchronous active-high reset
//   FIFO_EMPTY_I upstream FIFO has no data
//   FIFO_DATA_I  FIFO head word, valid while FIFO_EMPTY_I is low
//   FIFO_RE_O    one-cycle pop strobe (combinational)
//   TX_O         serial line, idle high (registered)
//   BUSY_O       a frame is on the line (registered)
//   DONE_O       one-cycle pulse in the first cycle after a frame ends
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       FIFO_EMPTY_I,
  input  logic [7:0] FIFO_DATA_I,
  output logic       FIFO_RE_O,
  output logic       TX_O,
  output logic       BUSY_O,
  output logic       DONE_O
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_last;
  logic             load;

  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_ONE;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;

    case (state)
      IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!FIFO_EMPTY_I) load = 1'b1;
      end
      START: begin
        if (cnt_last) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift[0];
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = '0;
            tx_d      = 1'b1;
          end else begin
            // The register shifts right each bit, so the next bit to send is
            // always at position 1 just before the shift takes effect.
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = {1'b0, shift[7:1]};
            tx_d      = shift[1];
          end
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx == STOP_LAST) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            if (!FIFO_EMPTY_I) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading a byte overrides everything above: straight into the start bit.
    if (load) begin
      state_d   = START;
      shift_d   = FIFO_DATA_I;
      cnt_d     = '0;
      bit_idx_d = '0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end

    FIFO_RE_O = load & ~RST_I;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TX_O   = tx_q;
  assign BUSY_O = busy_q;
  assign DONE_O = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level model
module tb_uart_tx;

  localparam int C    = 4;
  localparam int MAXC = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       re1, tx1, busy1, done1;
  logic       re2, tx2, busy2, done2;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .CLK_I(clk), .RST_I(rst), .FIFO_EMPTY_I(fifo_empty), .FIFO_DATA_I(fifo_data),
    .FIFO_RE_O(re1), .TX_O(tx1), .BUSY_O(busy1), .DONE_O(done1)
  );

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .CLK_I(clk), .RST_I(rst), .FIFO_EMPTY_I(fifo_empty), .FIFO_DATA_I(fifo_data),
    .FIFO_RE_O(re2), .TX_O(tx2), .BUSY_O(busy2), .DONE_O(done2)
  );

  int passed = 0;
  int total  = 0;
  int sel    = 1;

  logic [7:0] fifo_q[$];
  logic [7:0] mb[$];
  int         ms    = 1;
  int         mbase = 0;
  logic       obs[4][MAXC];
  string      sname[4] = '{"tx", "re", "busy", "done"};

  // Expected value of signal `which` (0 tx, 1 re, 2 busy, 3 done) at cycle c,
  // assuming every byte in mb is available from cycle mbase onward so frames
  // follow each other with no gap.
  function automatic logic exp_sig(input int which, input int c);
    int fl, rel, n, f, off, b;
    fl  = (9 + ms) * C;
    rel = c - mbase;
    n   = mb.size();
    case (which)
      1: return (rel % fl == 0) && (rel / fl < n);
      2: return (rel >= 1) && (rel <= n * fl);
      3: return (rel > fl) && ((rel - 1) % fl == 0) && ((rel - 1) / fl <= n);
      default: begin
        if (!((rel >= 1) && (rel <= n * fl))) return 1'b1;
        f   = (rel - 1) / fl;
        off = (rel - 1) % fl;
        b   = off / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return mb[f][b-1];
        return 1'b1;
      end
    endcase
  endfunction

  function automatic int first_bad(input int which, input int from, input int to);
    for (int c = from; c <= to; c++)
      if (obs[which][c] !== exp_sig(which, c)) return c;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    fifo_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs ncyc cycles serving the selected DUT from fifo_q, recording outputs
  // at the falling edge. RST_I is pulsed during cycle rst_at (none if -1).
  task automatic capture(input int ncyc, input int rst_at);
    logic re_now;
    for (int c = 0; c < ncyc; c++) begin
      rst        = (c == rst_at);
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = fifo_empty ? 8'($urandom) : fifo_q[0];
      @(negedge clk);
      re_now    = (sel == 1) ? re1 : re2;
      obs[0][c] = (sel == 1) ? tx1 : tx2;
      obs[1][c] = re_now;
      obs[2][c] = (sel == 1) ? busy1 : busy2;
      obs[3][c] = (sel == 1) ? done1 : done2;
      @(posedge clk);
      #1;
      if (re_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    rst = 1'b0;
    fifo_empty = 1'b1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    fifo_empty = 1'b0;
    fifo_data  = 8'h3C;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total += 8;
      if (tx1 !== 1'b1)   $display("FAIL reset_tx1 got %b expected 1", tx1);     else passed++;
      if (re1 !== 1'b0)   $display("FAIL reset_re1 got %b expected 0", re1);     else passed++;
      if (busy1 !== 1'b0) $display("FAIL reset_busy1 got %b expected 0", busy1); else passed++;
      if (done1 !== 1'b0) $display("FAIL reset_done1 got %b expected 0", done1); else passed++;
      if (tx2 !== 1'b1)   $display("FAIL reset_tx2 got %b expected 1", tx2);     else passed++;
      if (re2 !== 1'b0)   $display("FAIL reset_re2 got %b expected 0", re2);     else passed++;
      if (busy2 !== 1'b0) $display("FAIL reset_busy2 got %b expected 0", busy2); else passed++;
      if (done2 !== 1'b0) $display("FAIL reset_done2 got %b expected 0", done2); else passed++;
      @(posedge clk);
    end
    #1 rst = 1'b0;
    fifo_empty = 1'b1;
  endtask

  task automatic test_single();
    int bad;
    sel = 1; ms = 1; mbase = 0;
    mb = '{8'hA5};
    fifo_q = mb;
    do_reset();
    capture(50, -1);
    for (int w = 0; w < 4; w++) begin
      total++;
      bad = first_bad(w, 0, 49);
      if (bad != -1) $display("FAIL single_%s cycle %0d got %b expected %b", sname[w], bad, obs[w][bad], exp_sig(w, bad));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    sel = 1; ms = 1; mbase = 0;
    mb = '{8'h00, 8'hFF};
    fifo_q = mb;
    do_reset();
    capture(90, -1);
    for (int w = 0; w < 4; w++) begin
      total++;
      bad = first_bad(w, 0, 89);
      if (bad != -1) $display("FAIL b2b_%s cycle %0d got %b expected %b", sname[w], bad, obs[w][bad], exp_sig(w, bad));
      else passed++;
    end
    total++;
    if ({obs[1][40], obs[3][41], obs[3][81], obs[0][41], obs[0][45]} !== 5'b11101)
      $display("FAIL b2b_edges got %b expected 11101",
               {obs[1][40], obs[3][41], obs[3][81], obs[0][41], obs[0][45]});
    else passed++;
  endtask

  task automatic test_empty();
    int bad;
    sel = 1; ms = 1; mbase = 0;
    mb = {};
    fifo_q = {};
    do_reset();
    capture(100, -1);
    for (int w = 0; w < 4; w++) begin
      total++;
      bad = first_bad(w, 0, 99);
      if (bad != -1) $display("FAIL empty_%s cycle %0d got %b expected %b", sname[w], bad, obs[w][bad], exp_sig(w, bad));
      else passed++;
    end
  endtask

  task automatic test_random();
    int bad, n, ncyc;
    for (int it = 0; it < 3; it++) begin
      sel = 1; ms = 1; mbase = 0;
      n = $urandom_range(1, 4);
      mb = {};
      for (int i = 0; i < n; i++) mb.push_back(8'($urandom));
      fifo_q = mb;
      ncyc = n * 10 * C + 10;
      do_reset();
      capture(ncyc, -1);
      for (int w = 0; w < 4; w++) begin
        total++;
        bad = first_bad(w, 0, ncyc - 1);
        if (bad != -1) $display("FAIL random%0d_%s cycle %0d got %b expected %b", it, sname[w], bad, obs[w][bad], exp_sig(w, bad));
        else passed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    localparam int RA = 18;
    sel = 1; ms = 1; mbase = 0;
    mb = '{8'($urandom), 8'($urandom)};
    fifo_q = mb;
    do_reset();
    capture(RA + 1 + 50, RA);
    for (int w = 0; w < 4; w++) begin
      total++;
      bad = first_bad(w, 0, RA);
      if (bad != -1) $display("FAIL midrst_pre_%s cycle %0d got %b expected %b", sname[w], bad, obs[w][bad], exp_sig(w, bad));
      else passed++;
    end
    void'(mb.pop_front());
    mbase = RA + 1;
    for (int w = 0; w < 4; w++) begin
      total++;
      bad = first_bad(w, RA + 1, RA + 50);
      if (bad != -1) $display("FAIL midrst_post_%s cycle %0d got %b expected %b", sname[w], bad, obs[w][bad], exp_sig(w, bad));
      else passed++;
    end
  endtask

  task automatic test_two_stop();
    int bad;
    sel = 2; ms = 2; mbase = 0;
    mb = '{8'h5A, 8'($urandom)};
    fifo_q = mb;
    do_reset();
    capture(100, -1);
    for (int w = 0; w < 4; w++) begin
      total++;
      bad = first_bad(w, 0, 99);
      if (bad != -1) $display("FAIL stop2_%s cycle %0d got %b expected %b", sname[w], bad, obs[w][bad], exp_sig(w, bad));
      else passed++;
    end
    total++;
    if ({obs[3][45], obs[1][44], obs[0][37], obs[0][44]} !== 4'b1111)
      $display("FAIL stop2_edges got %b expected 1111", {obs[3][45], obs[1][44], obs[0][37], obs[0][44]});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_random();
    test_mid_reset();
    test_two_stop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per UART bit; legal range is 2 or more.
REQ-002 The module SHALL have parameter STOP_BITS, default 1, giving the number of stop bits; legal values are 1 and 2.
REQ-003 The module SHALL have port CLK_I, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port RST_I, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port FIFO_EMPTY_I, input, 1 bit: the upstream TX FIFO holds no data.
REQ-006 The module SHALL have port FIFO_DATA_I, input, 8 bits: the FIFO head word, first-word-fall-through (valid whenever FIFO_EMPTY_I=0).
REQ-007 The module SHALL have port FIFO_RE_O, output, 1 bit: a one-cycle pop strobe to the FIFO.
REQ-008 The module SHALL have port TX_O, output, 1 bit: the serial line, idle high.
REQ-009 The module SHALL have port BUSY_O, output, 1 bit: a frame is on the line.
REQ-010 The module SHALL have port DONE_O, output, 1 bit: a one-cycle pulse marking frame completion.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-012 The frame format SHALL be 8N1 or 8N2 according to STOP_BITS: start bit 0, data bits LSB first, stop bit(s) 1.
REQ-013 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, counting 0..CLKS_PER_BIT-1; terminal count ends the current bit.
REQ-014 In IDLE with FIFO_EMPTY_I=0 (cycle T), FIFO_RE_O SHALL be asserted combinationally in cycle T.
REQ-015 At the edge ending cycle T, the FSM SHALL capture FIFO_DATA_I into the shift register, enter START, and clear the counter.
REQ-016 FIFO_RE_O SHALL be high for exactly one cycle per frame and SHALL never be high while FIFO_EMPTY_I=1.
REQ-017 TX_O SHALL be registered: 0 from T+1 for CLKS_PER_BIT cycles, then data bits 0..7, then STOP_BITS stop bits, each bit lasting CLKS_PER_BIT cycles.
REQ-018 A 3-bit bit index SHALL advance in DATA at each terminal count; after bit 7, the FSM SHALL enter STOP.
REQ-019 BUSY_O SHALL be registered and high from T+1 through the last cycle of the final stop bit; it SHALL be low in IDLE.
REQ-020 DONE_O SHALL be high exactly one cycle, namely the first cycle after the final stop bit ends.
REQ-021 Back-to-back: if FIFO_EMPTY_I=0 in the terminal-count cycle of the final stop bit, the FSM SHALL assert FIFO_RE_O in that cycle, load the shift register, and go directly to START.
REQ-022 Back-to-back frames SHALL have no idle gap: frame period is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles, and DONE_O coincides with the next start bit's first cycle.
REQ-023 If FIFO_EMPTY_I=1 at the end of the final stop bit, the FSM SHALL enter IDLE with TX_O=1.
REQ-024 Once started, a frame SHALL never be aborted by FIFO_EMPTY_I changes; FIFO_DATA_I is ignored outside load cycles.

Reset
REQ-025 While RST_I=1 at a rising edge, the block SHALL load: state IDLE, TX_O=1, BUSY_O=0, DONE_O=0, counter=0, bit index=0, shift register=0x00.
REQ-026 While RST_I=1, FIFO_RE_O SHALL be held 0 regardless of FIFO_EMPTY_I.
REQ-027 Reset mid-frame SHALL return TX_O to 1 at the next edge; the in-flight byte is lost, and DONE_O SHALL NOT pulse for it.
REQ-028 In the first cycle with RST_I=0 and FIFO_EMPTY_I=0, the block SHALL behave per REQ-014.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
REQ-029 Reset scenario: RST_I=1 for 2 cycles with FIFO_EMPTY_I=0 -> TX_O=1, FIFO_RE_O=0, BUSY_O=0, DONE_O=0 throughout.
REQ-030 Single-byte scenario: FIFO holds 0xA5, cycle 0 -> FIFO_RE_O=1 in cycle 0 only; TX_O levels from cycle 1 are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; BUSY_O high for cycles 1-40; DONE_O=1 in cycle 41 only.
REQ-031 Back-to-back scenario: FIFO holds 0x00 then 0xFF -> FIFO_RE_O pulses in cycles 0 and 40; TX_O is 0 for cycles 1-36, 1 for 37-40, 0 for 41-44, and 1 for 45-80; DONE_O pulses in cycles 41 and 81; BUSY_O is continuously high for cycles 1-80.
REQ-032 Empty scenario: FIFO_EMPTY_I=1 for 100 cycles -> TX_O=1, FIFO_RE_O=0, BUSY_O=0 constant.
REQ-033 Mid-frame reset scenario: RST_I=1 for one cycle during data bit 3 -> TX_O=1 and BUSY_O=0 the next cycle, no DONE_O pulse; with FIFO non-empty, FIFO_RE_O=1 in the first cycle after reset deasserts.
REQ-034 Two-stop-bit scenario: STOP_BITS=2, byte 0x5A -> frame lasts 44 cycles, TX_O=1 for the final 8 cycles, and DONE_O fires in cycle 45.
